// File: rtl/word_counter_regs.sv
// word_counter_regs
// A bank of NUM_CNT event counters, CNT_W bits each, behind an Avalon-MM
// slave at BASE_ADDR. Counters either saturate or wrap at full scale
// (SATURATE). Each counter has a sticky overflow flag. Software can freeze
// the whole bank or clear it in one write.
//
// Register map, as byte offsets from BASE_ADDR. Only word-aligned offsets
// decode.
//   4*i           CNT[i]  read: zero-extended count, write: load
//   4*NUM_CNT     CTRL    bit0 CLEAR (write-1, reads 0), bit1 FREEZE (rw)
//   4*NUM_CNT+4   OVF     sticky overflow flags, write-1-to-clear
//
// Optional build macro:
//   CNT_CLEAR_ON_READ_EN  a read of CNT[i] also clears counter i on the same
//                         edge. A simultaneous increment still lands, so the
//                         counter becomes 1. FREEZE does not block this clear.
//                         When the macro is undefined, reads do not change state.
module word_counter_regs #(
  parameter int                      NUM_CNT      = 3,
  parameter int                      CNT_W        = 8,
  parameter int                      ADDRESS_SIZE = 32,
  parameter int                      REG_SIZE     = 32,
  parameter logic [ADDRESS_SIZE-1:0] BASE_ADDR    = 'h1000,
  parameter bit                      SATURATE     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CNT-1:0]      cnt_inc,
  input  logic [ADDRESS_SIZE-1:0] avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [REG_SIZE-1:0]     avs_writedata,
  output logic [REG_SIZE-1:0]     avs_readdata,
  output logic                    avs_readdatavalid
);

  localparam int NUM_REGS = NUM_CNT + 2;
  localparam int IDX_W    = $clog2(NUM_REGS);

  localparam logic [ADDRESS_SIZE-1:0] WIN_BYTES = ADDRESS_SIZE'(4 * NUM_REGS);
  localparam logic [IDX_W-1:0]        IDX_CTRL  = IDX_W'(NUM_CNT);
  localparam logic [IDX_W-1:0]        IDX_OVF   = IDX_W'(NUM_CNT + 1);
  localparam logic [CNT_W-1:0]        CNT_MAX   = {CNT_W{1'b1}};

  // Register state
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_d;
  logic [NUM_CNT-1:0]            ovf_q;
  logic [NUM_CNT-1:0]            ovf_d;
  logic [NUM_CNT-1:0]            ovf_set;
  logic [NUM_CNT-1:0]            ovf_clr;
  logic                          freeze_q;

  // Address decode
  logic [ADDRESS_SIZE-1:0] offset;
  logic                    hit;
  logic [IDX_W-1:0]        idx;
  logic [NUM_CNT-1:0]      cnt_sel;
  logic                    ctrl_sel;
  logic                    ovf_sel;

  // Bus qualifiers. A write always takes precedence over a read in the same cycle.
  logic                    wr;
  logic                    rd;
  logic                    clear_wr;
  logic [REG_SIZE-1:0]     rd_mux;

  // Only part of the offset and of the write data is meaningful.
  logic                    unused_bits;

  // Addresses below the window wrap to a huge offset, so the range check
  // rejects them without needing a separate lower-bound compare.
  assign offset   = avs_address - BASE_ADDR;
  assign hit      = (offset[1:0] == 2'b00) && (offset < WIN_BYTES);
  assign idx      = offset[IDX_W+1:2];
  assign ctrl_sel = hit && (idx == IDX_CTRL);
  assign ovf_sel  = hit && (idx == IDX_OVF);

  assign wr       = avs_write;
  assign rd       = avs_read && !avs_write;
  assign clear_wr = wr && ctrl_sel && avs_writedata[0];
  assign ovf_clr  = (wr && ovf_sel) ? avs_writedata[NUM_CNT-1:0] : '0;

  assign unused_bits = ^{avs_writedata, offset};

  // Per-counter select lines from the decoded word index
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_sel[i] = hit && (idx == IDX_W'(i));
    end
  end

  // Next count and new-overflow detection, in per-counter priority order
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (clear_wr) begin
        cnt_d[i] = '0;
      end else if (wr && cnt_sel[i]) begin
        cnt_d[i] = avs_writedata[CNT_W-1:0];
`ifdef CNT_CLEAR_ON_READ_EN
      end else if (rd && cnt_sel[i]) begin
        // The increment applies to the cleared value, so it cannot overflow.
        cnt_d[i] = CNT_W'(cnt_inc[i]);
`endif
      end else if (!freeze_q && cnt_inc[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
          cnt_d[i]   = SATURATE ? CNT_MAX : '0;
        end else begin
          cnt_d[i]   = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sticky flags. If a flag is set and cleared in the same cycle, it stays set.
  always_comb begin
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  // Counter, overflow and freeze registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      ovf_q    <= '0;
      freeze_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (wr && ctrl_sel) begin
        freeze_q <= avs_writedata[1];
      end
    end
  end

  // Read-data mux over the pre-update register state. CLEAR always reads 0.
  always_comb begin
    rd_mux = '0;
    if (ctrl_sel) begin
      rd_mux[1] = freeze_q;
    end else if (ovf_sel) begin
      rd_mux[NUM_CNT-1:0] = ovf_q;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (cnt_sel[i]) begin
          rd_mux[CNT_W-1:0] = cnt_q[i];
        end
      end
    end
  end

  // Read response, one cycle after the read strobe. Data holds until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= rd;
      if (rd) begin
        avs_readdata <= rd_mux;
      end
    end
  end

endmodule
